instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/salamander_pkg.sv | 14 +
 rtl/instr_mem.sv | 32 +++
 rtl/instr_fetch.sv | 108 ++++++++++
 tb/tb_instr_fetch.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/salamander_pkg.sv
// Shared widths and the fetch sequencer state encoding for the salamander core front end.
package salamander_pkg;

    localparam int INSTR_W_DEF = 6;
    localparam int PC_W_DEF    = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/instr_mem.sv
// Program store: one synchronous write port, one registered read port.
// Latency 1 cycle on read; the read register holds its value when rd_en is low.
module instr_mem #(
    parameter int INSTR_W = 6,
    parameter int PC_W    = 4
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               we,
    input  logic [PC_W-1:0]    wr_addr,
    input  logic [INSTR_W-1:0] wr_data,
    input  logic               rd_en,
    input  logic [PC_W-1:0]    rd_addr,
    output logic [INSTR_W-1:0] rd_data
);

    logic [INSTR_W-1:0] mem [2**PC_W];

    // Storage is deliberately not reset so a program survives an aborted run.
    always_ff @(posedge clk) begin
        if (we)
            mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            rd_data <= '0;
        else if (rd_en)
            rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: streams mem[0..end_addr] to the decoder, one per cycle.
// First ID_CE two cycles after start; stall/halt gate ID_CE in the same cycle. INSTR_FETCH_LOOP_EN wraps instead of ending.
module instr_fetch
    import salamander_pkg::*;
#(
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int PC_W    = PC_W_DEF
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    input  logic               halt,
    input  logic               stall,
    input  logic [PC_W-1:0]    end_addr,
    input  logic               load_en,
    input  logic [PC_W-1:0]    load_addr,
    input  logic [INSTR_W-1:0] load_data,
    output logic [INSTR_W-1:0] INSTR,
    output logic               ID_CE,
    output logic [PC_W-1:0]    PC,
    output logic               busy,
    output logic               done
);

    fetch_state_t    state;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] end_q;
    logic [PC_W-1:0] pc_nxt;
    logic            rd_en;
    logic            issue;
    logic            at_end;

    assign issue  = (state == RUN) && !stall && !halt;
    assign at_end = (pc_q == end_q);

    // The memory is addressed with the next PC so the registered read lands
    // on INSTR in the same edge that PC advances.
    always_comb begin
        pc_nxt = pc_q;
        rd_en  = 1'b0;
        if (state == FETCH && !halt) begin
            rd_en = 1'b1;
        end else if (issue) begin
            if (!at_end) begin
                pc_nxt = pc_q + 1'b1;
                rd_en  = 1'b1;
            end
`ifdef INSTR_FETCH_LOOP_EN
            else begin
                pc_nxt = '0;
                rd_en  = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            pc_q  <= '0;
            end_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !halt) begin
                        state <= FETCH;
                        pc_q  <= '0;
                        end_q <= end_addr;
                    end
                end
                FETCH: state <= halt ? IDLE : RUN;
                RUN: begin
                    if (halt) begin
                        state <= IDLE;
                    end else if (!stall) begin
                        pc_q <= pc_nxt;
`ifndef INSTR_FETCH_LOOP_EN
                        if (at_end)
                            state <= DONE;
`endif
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    instr_mem #(
        .INSTR_W (INSTR_W),
        .PC_W    (PC_W)
    ) u_mem (
        .clk     (clk),
        .rstn    (rstn),
        .we      (load_en && (state == IDLE)),
        .wr_addr (load_addr),
        .wr_data (load_data),
        .rd_en   (rd_en),
        .rd_addr (pc_nxt),
        .rd_data (INSTR)
    );

    assign ID_CE = issue;
    assign PC    = pc_q;
    assign busy  = (state != IDLE);
    assign done  = (state == DONE);

endmodule

// File: tb/tb_instr_fetch.sv
// Randomised and directed bench for instr_fetch against a cycle-level run model.
module tb_instr_fetch;

`ifdef INSTR_FETCH_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    localparam int P_IDLE = 0, P_PRIME = 1, P_ISSUE = 2, P_END = 3;

    logic       clk = 1'b0;
    logic       rstn;
    logic       start, halt, stall, load_en;
    logic [3:0] end_addr, load_addr;
    logic [5:0] load_data;
    logic [5:0] instr;
    logic       id_ce, busy, done;
    logic [3:0] pc;

    instr_fetch #(.INSTR_W(6), .PC_W(4)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .halt      (halt),
        .stall     (stall),
        .end_addr  (end_addr),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .INSTR     (instr),
        .ID_CE     (id_ce),
        .PC        (pc),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference: program array plus where the run is and what the decoder last saw.
    logic [5:0] m_mem [16];
    int         m_ph, m_pc, m_end;
    logic [5:0] m_instr;

    int cyc = 0, ce_cnt = 0, done_cnt = 0, first_ce = -1, start_cyc = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ph = P_IDLE; m_pc = 0; m_end = 0; m_instr = '0;
    endtask

    task automatic model_edge();
        case (m_ph)
            P_IDLE: begin
                if (load_en) m_mem[load_addr] = load_data;
                if (start && !halt) begin
                    m_ph = P_PRIME; m_pc = 0; m_end = end_addr;
                end
            end
            P_PRIME: begin
                if (halt) m_ph = P_IDLE;
                else begin m_instr = m_mem[0]; m_ph = P_ISSUE; end
            end
            P_ISSUE: begin
                if (halt) m_ph = P_IDLE;
                else if (!stall) begin
                    if (m_pc == m_end) begin
                        if (LOOP) begin m_pc = 0; m_instr = m_mem[0]; end
                        else m_ph = P_END;
                    end else begin
                        m_pc = (m_pc + 1) % 16;
                        m_instr = m_mem[m_pc];
                    end
                end
            end
            default: m_ph = P_IDLE;
        endcase
    endtask

    // Called at a negedge with inputs already set; returns at the next negedge.
    task automatic step();
        #1;
        chk("id_ce", id_ce, (m_ph == P_ISSUE) && !stall && !halt);
        chk("instr", instr, m_instr);
        chk("pc",    pc,    m_pc[3:0]);
        chk("busy",  busy,  m_ph != P_IDLE);
        chk("done",  done,  m_ph == P_END);
        if (id_ce) begin
            ce_cnt++;
            if (first_ce < 0) first_ce = cyc;
        end
        if (done) done_cnt++;
        @(posedge clk);
        model_edge();
        cyc++;
        @(negedge clk);
    endtask

    task automatic load(input int a, input logic [5:0] d);
        load_en = 1'b1; load_addr = 4'(a); load_data = d;
        step();
        load_en = 1'b0;
    endtask

    // One run; optional two-cycle stall at stall_pc and halt (with stall and a stray load) at halt_pc.
    task automatic run_prog(input int e, input int stall_pc, input int halt_pc, input int max);
        int stalls = 0;
        ce_cnt = 0; done_cnt = 0; first_ce = -1;
        end_addr = 4'(e); start = 1'b1; start_cyc = cyc;
        step();
        start = 1'b0;
        for (int i = 0; i < max && m_ph != P_IDLE; i++) begin
            halt    = (m_ph == P_ISSUE) && (m_pc == halt_pc);
            stall   = halt || ((m_ph == P_ISSUE) && (m_pc == stall_pc) && stalls < 2);
            load_en = (halt_pc >= 0);
            load_addr = 4'd1; load_data = 6'h3f;
            if (stall && !halt) stalls++;
            step();
        end
        halt = 1'b0; stall = 1'b0; load_en = 1'b0;
        chk("run_terminates", busy, 1'b0);
    endtask

    initial begin
        rstn = 1'b0; start = 0; halt = 0; stall = 0; load_en = 0;
        end_addr = '0; load_addr = '0; load_data = '0;
        model_reset();
        @(negedge clk); @(negedge clk);
        #1;
        chk("rst_instr", instr, 6'h00);
        chk("rst_pc",    pc,    4'h0);
        chk("rst_id_ce", id_ce, 1'b0);
        chk("rst_busy",  busy,  1'b0);
        chk("rst_done",  done,  1'b0);
        @(negedge clk);
        rstn = 1'b1;

        for (int a = 0; a < 16; a++) load(a, 6'($urandom));
        for (int a = 0; a < 4; a++) load(a, 6'(a));

`ifndef INSTR_FETCH_LOOP_EN
        run_prog(3, -1, -1, 20);
        chk("s1_ce_count", ce_cnt, 4);
        chk("s1_first_ce_latency", first_ce - start_cyc, 2);
        chk("s1_done_count", done_cnt, 1);

        run_prog(3, 1, -1, 20);
        chk("s2_ce_count", ce_cnt, 4);
        chk("s2_done_count", done_cnt, 1);

        load(0, 6'h25);
        run_prog(0, -1, -1, 20);
        chk("s3_ce_count", ce_cnt, 1);
        chk("s3_done_count", done_cnt, 1);

        load(0, 6'h00);
        run_prog(3, -1, 2, 20);
        chk("s4_ce_count", ce_cnt, 2);
        chk("s4_done_count", done_cnt, 0);
        run_prog(3, -1, -1, 20);
        chk("s4_mem_intact_ce", ce_cnt, 4);

        end_addr = 4'd3; start = 1'b1; step(); start = 1'b0;
        step(); step(); step();
        rstn = 1'b0;
        #1;
        chk("mid_rst_instr", instr, 6'h00);
        chk("mid_rst_pc",    pc,    4'h0);
        chk("mid_rst_id_ce", id_ce, 1'b0);
        chk("mid_rst_busy",  busy,  1'b0);
        chk("mid_rst_done",  done,  1'b0);
        model_reset();
        @(posedge clk); @(negedge clk);
        rstn = 1'b1;
        run_prog(3, -1, -1, 20);
        chk("s5_ce_count", ce_cnt, 4);
        chk("s5_first_ce_latency", first_ce - start_cyc, 2);
        chk("s5_done_count", done_cnt, 1);
`else
        done_cnt = 0; ce_cnt = 0;
        end_addr = 4'd1; start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 12; i++) step();
        chk("loop_ce_count", ce_cnt, 11);
        halt = 1'b1; step(); halt = 1'b0;
        step();
        chk("loop_done_count", done_cnt, 0);
        chk("loop_halted", busy, 1'b0);
`endif

        for (int i = 0; i < 600; i++) begin
            start     = ($urandom_range(0, 3) == 0);
            halt      = ($urandom_range(0, 15) == 0);
            stall     = ($urandom_range(0, 3) == 0);
            load_en   = ($urandom_range(0, 2) == 0);
            load_addr = 4'($urandom);
            load_data = 6'($urandom);
            end_addr  = 4'($urandom);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
